// File: rtl/perceptron_neuron_fwd.sv
// Sequential Q32.32 neuron forward pass: bias + sum(x*w), then Step/Sigmoid/Tanh/ReLU activation.
// Define PERCEPTRON_SATURATE_EN for saturating arithmetic and a sticky overflow flag.
module perceptron_neuron_fwd #(
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned FRAC_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  act_sel,
    input  logic [63:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_x,
    input  logic [63:0] in_w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_y,
    output logic [63:0] out_net,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic signed [DATA_W-1:0] ONE  = 64'sd1 <<< FRAC_BITS;
    localparam logic signed [DATA_W-1:0] HALF = ONE >>> 1;

`ifdef PERCEPTRON_SATURATE_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] PMAX    = PROD_W'(SAT_MAX);
    localparam logic signed [PROD_W-1:0] PMIN    = PROD_W'(SAT_MIN);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ACT   = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    state_e              state_q;
    logic [1:0]          act_q;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   prod_q;
    logic                prod_vld_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_y_q;
    logic [DATA_W-1:0]   out_net_q;

    logic signed [PROD_W-1:0] prod_full;
    logic [DATA_W-1:0]        mul_val;
    logic [DATA_W-1:0]        acc_d;
    logic [DATA_W-1:0]        act_y;
    logic signed [DATA_W-1:0] sig_v;

`ifdef PERCEPTRON_SATURATE_EN
    logic signed [PROD_W-1:0] prod_shift;
    logic                     mul_sat;
    logic [DATA_W-1:0]        acc_sum;
    logic                     acc_ovf;
    logic                     ovf_q;
`endif

    // Full signed product rescaled to Q32.32 (floor via arithmetic shift).
    always_comb begin
        prod_full = $signed({{DATA_W{in_x[DATA_W-1]}}, in_x})
                  * $signed({{DATA_W{in_w[DATA_W-1]}}, in_w});
`ifdef PERCEPTRON_SATURATE_EN
        prod_shift = prod_full >>> FRAC_BITS;
        mul_sat    = (prod_shift > PMAX) || (prod_shift < PMIN);
        mul_val    = mul_sat ? (prod_shift[PROD_W-1] ? SAT_MIN : SAT_MAX)
                             : prod_shift[DATA_W-1:0];
`else
        mul_val    = DATA_W'(prod_full >>> FRAC_BITS);
`endif
    end

    // Accumulator update from the registered product of the previous accepted pair.
    always_comb begin
`ifdef PERCEPTRON_SATURATE_EN
        acc_sum = acc_q + prod_q;
        acc_ovf = (acc_q[DATA_W-1] == prod_q[DATA_W-1]) &&
                  (acc_sum[DATA_W-1] != acc_q[DATA_W-1]);
        acc_d   = acc_ovf ? (acc_q[DATA_W-1] ? SAT_MIN : SAT_MAX) : acc_sum;
`else
        acc_d   = acc_q + prod_q;
`endif
    end

    // Activation of the final net sum.
    always_comb begin
        act_y = '0;
        sig_v = ($signed(acc_q) >>> 2) + HALF;
        case (act_q)
            2'd0: act_y = acc_q[DATA_W-1] ? '0 : ONE;
            2'd1: begin
                if (sig_v[DATA_W-1])  act_y = '0;
                else if (sig_v > ONE) act_y = ONE;
                else                  act_y = sig_v;
            end
            2'd2: begin
                if ($signed(acc_q) < -ONE)     act_y = -ONE;
                else if ($signed(acc_q) > ONE) act_y = ONE;
                else                           act_y = acc_q;
            end
            default: act_y = acc_q[DATA_W-1] ? '0 : acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            act_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_net_q   <= '0;
`ifdef PERCEPTRON_SATURATE_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            prod_vld_q <= 1'b0;
            if (prod_vld_q) begin
                acc_q <= acc_d;
`ifdef PERCEPTRON_SATURATE_EN
                if (acc_ovf) ovf_q <= 1'b1;
`endif
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q      <= bias;
                        act_q      <= act_sel;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_ACCUM;
`ifdef PERCEPTRON_SATURATE_EN
                        ovf_q      <= 1'b0;
`endif
                    end
                end
                S_ACCUM: begin
                    if (in_valid && in_ready_q) begin
                        prod_q     <= mul_val;
                        prod_vld_q <= 1'b1;
                        cnt_q      <= cnt_q + CNT_W'(1);
`ifdef PERCEPTRON_SATURATE_EN
                        if (mul_sat) ovf_q <= 1'b1;
`endif
                        if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_ACT;
                        end
                    end
                end
                S_ACT: begin
                    // Wait one cycle for the last product to land in the accumulator.
                    if (!prod_vld_q) begin
                        out_net_q   <= acc_q;
                        out_y_q     <= act_y;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_net   = out_net_q;
`ifdef PERCEPTRON_SATURATE_EN
    assign overflow  = ovf_q;
`else
    assign overflow  = 1'b0;
`endif

endmodule
